// File: rtl/mpp_pattern_sequencer.sv
// MPP drive-waveform source: runtime-loadable signed pattern tables played back
// with gain scaling, saturation, valid/ready output handshake and end-of-period stop.
module mpp_pattern_sequencer #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 17,
  parameter int NUM_PATTERNS = 4,
  parameter int GAIN_W       = 8,
  parameter int REP_W        = 8,
  localparam int ADDR_W      = $clog2(DEPTH),
  localparam int PAT_W       = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [PAT_W-1:0]  wrPattern,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              start,
  input  logic [PAT_W-1:0]  patternSel,
  input  logic [REP_W-1:0]  repeatCount,
  input  logic [GAIN_W-1:0] gain,
  input  logic              stopReq,
  input  logic              sampleReady,
  output logic [DATA_W-1:0] MPPsignal_out,
  output logic              sampleValid,
  output logic              busy,
  output logic              done
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(GAIN_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(GAIN_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg;
  logic [PAT_W-1:0]  sel_reg;
  logic [REP_W-1:0]  rep_reg;
  logic [REP_W-1:0]  period_reg;
  logic [GAIN_W-1:0] gain_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              stop_reg;
  logic [DATA_W-1:0] out_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [DATA_W-1:0] tbl [NUM_PATTERNS][DEPTH];

  // Range checks done on zero-extended copies so the compare stays generic
  // for any NUM_PATTERNS, power of two or not.
  logic [31:0] wr_pat_ext;
  logic [31:0] wr_addr_ext;
  logic [31:0] start_pat_ext;
  logic        wr_ok;
  logic        start_ok;

  assign wr_pat_ext    = 32'(wrPattern);
  assign wr_addr_ext   = 32'(wrAddr);
  assign start_pat_ext = 32'(patternSel);
  assign wr_ok    = wrEn && (wr_addr_ext < DEPTH) && (wr_pat_ext < NUM_PATTERNS)
                    && !(busy_reg && (wrPattern == sel_reg));
  assign start_ok = start && (start_pat_ext < NUM_PATTERNS);

  always_ff @(posedge clk) begin
    if (wr_ok) tbl[wrPattern][wrAddr] <= wrData;
  end

  logic [PAT_W-1:0]          rd_pat;
  logic [ADDR_W-1:0]         rd_addr;
  logic [ADDR_W-1:0]         nxt_idx;
  logic [GAIN_W-1:0]         rd_gain;
  logic signed [DATA_W-1:0]  rd_sample;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  shifted;
  logic [DATA_W-1:0]         scaled;
  logic                      final_period;

  // The read port looks one sample ahead: entry 0 of the requested pattern in
  // IDLE, the next index of the active pattern in RUN.
  always_comb begin
    nxt_idx = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    if (state_reg == IDLE) begin
      rd_pat  = patternSel;
      rd_addr = '0;
      rd_gain = gain;
    end else begin
      rd_pat  = sel_reg;
      rd_addr = nxt_idx;
      rd_gain = gain_reg;
    end
    rd_sample = $signed(tbl[rd_pat][rd_addr]);
    prod      = rd_sample * $signed({1'b0, rd_gain});
    shifted   = prod >>> (GAIN_W - 1);
    if (shifted > SAT_MAX)      scaled = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) scaled = SAT_MIN[DATA_W-1:0];
    else                        scaled = shifted[DATA_W-1:0];
    final_period = (rep_reg != '0) && (period_reg == rep_reg - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      rep_reg    <= '0;
      period_reg <= '0;
      gain_reg   <= '0;
      idx_reg    <= '0;
      stop_reg   <= 1'b0;
      out_reg    <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            sel_reg    <= patternSel;
            rep_reg    <= repeatCount;
            gain_reg   <= gain;
            period_reg <= '0;
            idx_reg    <= '0;
            stop_reg   <= 1'b0;
            out_reg    <= scaled;
            valid_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (stopReq) stop_reg <= 1'b1;
          if (valid_reg && sampleReady) begin
            // A stop request arriving on the final handshake still counts.
            if ((idx_reg == LAST_IDX) && (final_period || stop_reg || stopReq)) begin
              out_reg   <= '0;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              out_reg <= scaled;
              idx_reg <= nxt_idx;
              if (idx_reg == LAST_IDX) period_reg <= period_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MPPsignal_out = out_reg;
  assign sampleValid   = valid_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_mpp_pattern_sequencer.sv
// Scoreboard bench for mpp_pattern_sequencer: the driver queues expected samples,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_mpp_pattern_sequencer;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 17;
  localparam int PAT_W  = 2;
  localparam int ADDR_W = 5;
  localparam int GAIN_W = 8;
  localparam int REP_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wrEn = 1'b0;
  logic [PAT_W-1:0]  wrPattern = '0;
  logic [ADDR_W-1:0] wrAddr = '0;
  logic [DATA_W-1:0] wrData = '0;
  logic              start = 1'b0;
  logic [PAT_W-1:0]  patternSel = '0;
  logic [REP_W-1:0]  repeatCount = '0;
  logic [GAIN_W-1:0] gain = '0;
  logic              stopReq = 1'b0;
  logic              sampleReady = 1'b1;
  logic [DATA_W-1:0] MPPsignal_out;
  logic              sampleValid;
  logic              busy;
  logic              done;

  int p0   [DEPTH] = '{1920, 1920, -1920, -1920, -1583, 1920, 1920, 800, -1920, -1920, 0,
                       1920, 1920, -801, -1920, -1920, 1583};
  int g255 [DEPTH] = '{3825, 3825, -3825, -3825, -3154, 3825, 3825, 1593, -3825, -3825, 0,
                       3825, 3825, -1596, -3825, -3825, 3153};
  int g64  [DEPTH] = '{960, 960, -960, -960, -792, 960, 960, 400, -960, -960, 0,
                       960, 960, -401, -960, -960, 791};

  logic signed [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  bit ready_rand = 1'b0;

  mpp_pattern_sequencer dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrPattern(wrPattern), .wrAddr(wrAddr),
    .wrData(wrData), .start(start), .patternSel(patternSel), .repeatCount(repeatCount),
    .gain(gain), .stopReq(stopReq), .sampleReady(sampleReady),
    .MPPsignal_out(MPPsignal_out), .sampleValid(sampleValid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_rand) sampleReady = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every accepted sample and check that stalled output holds.
  initial begin
    logic                     stall_prev;
    logic [DATA_W-1:0]        prev_out;
    logic signed [DATA_W-1:0] e;
    stall_prev = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_hold_data", $signed(MPPsignal_out), $signed(prev_out));
          chk("stall_hold_valid", sampleValid, 1);
        end
        if (sampleValid && sampleReady) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_sample", $signed(MPPsignal_out), 64'sd999999999);
          end else begin
            e = exp_q.pop_front();
            $display("[cyc %0d] sample #%0d accepted: %0d (expected %0d)",
                     cyc, hs_count, $signed(MPPsignal_out), e);
            chk("sample", $signed(MPPsignal_out), e);
          end
          hs_count++;
          last_hs_cyc = cyc;
        end
        stall_prev = sampleValid && !sampleReady;
        prev_out   = MPPsignal_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input int d);
    wrEn = 1'b1; wrPattern = PAT_W'(p); wrAddr = ADDR_W'(a); wrData = DATA_W'(d);
    tick();
    wrEn = 1'b0;
  endtask

  task automatic push_val(input int v);
    exp_q.push_back(DATA_W'(v));
  endtask

  task automatic start_run(input int pat, input int rep, input int g);
    hs_count = 0;
    patternSel = PAT_W'(pat); repeatCount = REP_W'(rep); gain = GAIN_W'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid_latency", sampleValid, 1);
    chk("busy_in_run", busy, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({name, "_done_timeout"}, 0, 1);
    end else begin
      chk({name, "_all_accepted"}, exp_q.size(), 0);
      chk({name, "_done_valid_low"}, sampleValid, 0);
      chk({name, "_done_latency"}, cyc, last_hs_cyc + 1);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, done, 0);
      chk({name, "_busy_low"}, busy, 0);
      chk({name, "_idle_out_zero"}, $signed(MPPsignal_out), 0);
    end
    exp_q.delete();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    chk("reset_out", $signed(MPPsignal_out), 0);
    chk("reset_valid", sampleValid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) wr(0, i, p0[i]);

    // T1: unity gain, two periods, full throughput
    for (int r = 0; r < 2; r++) for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    start_run(0, 2, 128);
    wait_done("t1", 100);

    // T2: gain above and below unity, floor rounding
    for (int i = 0; i < DEPTH; i++) push_val(g255[i]);
    start_run(0, 1, 255);
    wait_done("t2_g255", 100);
    for (int i = 0; i < DEPTH; i++) push_val(g64[i]);
    start_run(0, 1, 64);
    wait_done("t2_g64", 100);

    // T3: saturation at both rails
    for (int i = 0; i < DEPTH; i++) wr(1, i, 8388607);
    for (int i = 0; i < DEPTH; i++) push_val(8388607);
    start_run(1, 1, 255);
    wait_done("t3_pos", 100);
    for (int i = 0; i < DEPTH; i++) wr(1, i, -8388608);
    for (int i = 0; i < DEPTH; i++) push_val(-8388608);
    start_run(1, 1, 255);
    wait_done("t3_neg", 100);

    // T4: stopReq in IDLE must not shorten the next run
    stopReq = 1'b1;
    tick();
    stopReq = 1'b0;
    tick();
    for (int r = 0; r < 2; r++) for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    start_run(0, 2, 128);
    wait_done("t4_idle_stop", 100);

    // T4: endless run stopped at sample 5 of the third period
    for (int r = 0; r < 3; r++) for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    start_run(0, 0, 128);
    for (int n = 0; n < 200 && hs_count < 2 * DEPTH + 5; n++) tick();
    chk("t4_stop_point", hs_count, 2 * DEPTH + 5);
    stopReq = 1'b1;
    tick();
    stopReq = 1'b0;
    wait_done("t4_stop", 200);

    // T5: random backpressure
    for (int r = 0; r < 2; r++) for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    ready_rand = 1'b1;
    start_run(0, 2, 128);
    wait_done("t5", 600);
    ready_rand = 1'b0;
    tick();
    sampleReady = 1'b1;
    tick();

    // T6: reset mid-run
    for (int r = 0; r < 2; r++) for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    start_run(0, 2, 128);
    for (int n = 0; n < 100 && hs_count < 9; n++) tick();
    chk("t6_reset_point", hs_count, 9);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out", $signed(MPPsignal_out), 0);
    chk("t6_rst_valid", sampleValid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t6_no_done_after_rst", done, 0);
    end
    tick();

    // T6: restart from sample 0; write to active pattern ignored, other pattern taken
    for (int i = 0; i < DEPTH; i++) wr(2, i, i * 100 - 800);
    for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    start_run(0, 1, 128);
    wr(0, 16, 5);
    wr(2, 0, 1234);
    wait_done("t6_restart", 100);
    push_val(1234);
    for (int i = 1; i < DEPTH; i++) push_val(i * 100 - 800);
    start_run(2, 1, 128);
    wait_done("t6_other_pattern", 100);
    for (int i = 0; i < DEPTH; i++) push_val(p0[i]);
    start_run(0, 1, 128);
    wait_done("t6_active_unchanged", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
